// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the serial adder controller
//
// Purpose: controller FSM state encoding and the default operand width.
// Ports:   none (package).

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit gate-level full adder
//
// Purpose: one bit of addition; the serial controller reuses this cell every cycle.
// Ports:
//   a, b  - operand bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign s       = a_xor_b ^ ci;
    assign co      = (a & b) | (ci & a_xor_b);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder sequencing one full-adder cell
//
// Purpose: accepts an operand pair on start, adds LSB first one bit per clock
//          through a single full_adder_cell, then pulses done with registered
//          sum/cout. {cout, sum} = a + b + cin.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only in IDLE
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry in, captured on the accepting edge
//   busy   - high in RUN and DONE
//   done   - one-cycle completion pulse
//   sum    - WIDTH-bit result, updates only on completion
//   cout   - final carry out, updates only on completion

module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sha_q;
    logic [WIDTH-1:0] shb_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_d;

    full_adder_cell u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Result fills from the MSB end so after WIDTH shifts bit 0 sits at bit 0.
    assign res_d = {fa_s, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sha_q   <= '0;
            shb_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sha_q   <= a;
                        shb_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sha_q   <= sha_q >> 1;
                    shb_q   <= shb_q >> 1;
                    carry_q <= fa_co;
                    res_q   <= res_d;
                    // Last bit: publish the completed result on this same edge
                    // and leave the counter at WIDTH-1 so it never wraps.
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_co;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl

module tb_serial_adder_ctrl;

    localparam int W       = 8;
    localparam int TIMEOUT = 40;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int nvec = 0;
    int nerr = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = {1'b0, x};
        r = r + {1'b0, y};
        r = r + {{W{1'b0}}, c};
        return r;
    endfunction

    // Present operands with start for one edge (E0); returns at E0+1.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges elapsed until done is observed high; TIMEOUT if it never arrives.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < TIMEOUT);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        nvec++;
        if ({busy, done, cout, sum} !== '0) begin
            nerr++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, cout, sum});
        end
        #11 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({busy, done} !== 2'b00) begin
            nerr++; $display("FAIL idle_hold: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] vb [4] = '{8'h3C, 8'h01, 8'hFF, 8'h00};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   exp;
        logic [W:0]   prev;
        int           lat;
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            exp = model(va[i], vb[i], vc[i]);
            issue(va[i], vb[i], vc[i]);
            nvec++;
            if (busy !== 1'b1) begin
                nerr++; $display("FAIL busy_rise[%0d]: got %b expected 1", i, busy);
            end
            repeat (4) @(posedge clk);
            #1;
            nvec++;
            if ({cout, sum} !== prev || done !== 1'b0) begin
                nerr++; $display("FAIL hold_prev[%0d]: got %h done=%b expected %h done=0", i, {cout, sum}, done, prev);
            end
            wait_done(lat);
            nvec++;
            if (lat !== W - 4) begin
                nerr++; $display("FAIL latency[%0d]: got %0d expected %0d", i, lat + 4, W);
            end
            nvec++;
            if ({cout, sum} !== exp) begin
                nerr++; $display("FAIL result[%0d]: got %h expected %h", i, {cout, sum}, exp);
            end
            @(posedge clk); #1;
            nvec++;
            if ({busy, done} !== 2'b00) begin
                nerr++; $display("FAIL return_idle[%0d]: got busy=%b done=%b expected 0 0", i, busy, done);
            end
            prev = exp;
        end
    endtask

    task automatic test_ignore_start();
        logic [W:0] exp;
        int         lat;
        int         pulses;
        exp = model(8'h37, 8'h81, 1'b1);
        issue(8'h37, 8'h81, 1'b1);
        @(posedge clk); #1;                       // E1+1
        @(posedge clk); #1;                       // E2+1
        a = 8'hAA; b = 8'hAA; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E3 sampled start while busy
        start = 1'b0;
        wait_done(lat);
        nvec++;
        if (lat !== W - 3) begin
            nerr++; $display("FAIL ignore_latency: got %0d expected %0d", lat + 3, W);
        end
        a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;                       // start seen in DONE
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        nvec++;
        if (pulses !== 0 || busy !== 1'b0) begin
            nerr++; $display("FAIL ignore_extra: got pulses=%0d busy=%b expected 0 0", pulses, busy);
        end
        nvec++;
        if ({cout, sum} !== exp) begin
            nerr++; $display("FAIL ignore_result: got %h expected %h", {cout, sum}, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] exp;
        int         lat;
        int         pulses;
        issue(8'hC3, 8'h5E, 1'b1);
        repeat (3) @(posedge clk);                // now just after E3, before E4
        #1;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy, done, cout, sum} !== '0) begin
            nerr++; $display("FAIL abort_outputs: got %h expected 0", {busy, done, cout, sum});
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        nvec++;
        if (pulses !== 0) begin
            nerr++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exp = model(8'h9C, 8'h47, 1'b0);
        issue(8'h9C, 8'h47, 1'b0);
        wait_done(lat);
        nvec++;
        if (lat !== W || {cout, sum} !== exp) begin
            nerr++; $display("FAIL post_reset_op: got lat=%0d %h expected lat=%0d %h", lat, {cout, sum}, W, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vc[i] = 1'($urandom);
        end
        a = va[0]; b = vb[0]; cin = vc[0]; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = model(va[i], vb[i], vc[i]);
            wait_done(lat);
            nvec++;
            if (lat !== ((i == 0) ? W + 1 : W + 2)) begin
                nerr++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, lat, (i == 0) ? W + 1 : W + 2);
            end
            nvec++;
            if ({cout, sum} !== exp) begin
                nerr++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, {cout, sum}, exp);
            end
            if (i < 2) begin
                a = va[i+1]; b = vb[i+1]; cin = vc[i+1];
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   exp;
        int           lat;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i == 0) begin ra = '1; rb = '1; rc = 1'b0; end
            exp = model(ra, rb, rc);
            issue(ra, rb, rc);
            wait_done(lat);
            nvec++;
            if (lat !== W || {cout, sum} !== exp) begin
                nerr++; $display("FAIL random[%0d]: a=%h b=%h cin=%b got lat=%0d %h expected lat=%0d %h",
                                 i, ra, rb, rc, lat, {cout, sum}, W, exp);
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
